f_fetch_unit: RTL and testbench

- Fetch-stage producer for the F→D pipeline register in the five-stage MIPS pipeline (delayed-branch ISA).
- Holds the PC and addresses instruction memory.
- Applies branch/jump redirects resolved in D, and presents PC_F/Instr_F to the F→D register.
- Honours the same stall enable the hazard unit drives into the F→D register.

---
 rtl/f_fetch_unit.sv | 82 ++++++++
 tb/tb_f_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_unit.sv
// Fetch stage of a five-stage delayed-branch MIPS pipeline: PC register, next-PC
// selection from D-stage redirects, IM addressing and fault/nop gating.
module f_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_F,
  input  logic [1:0]       npc_sel,
  input  logic             br_taken,
  input  logic [31:0]      PC_D,
  input  logic [15:0]      imm16_D,
  input  logic [25:0]      index26_D,
  input  logic [31:0]      jr_target_D,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      PC_F,
  output logic [31:0]      Instr_F,
  output logic             fetch_fault,
  output logic [31:0]      fetch_cnt
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] jr;
  } npc_cand_t;

  // One past the last IM byte; 33 bits so a window ending at 2^32 cannot wrap.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  logic [31:0] npc;
  logic [31:0] br_off;
  npc_cand_t   cand;

  assign br_off   = {{14{imm16_D[15]}}, imm16_D, 2'b00};
  assign cand.seq = pc_q + 32'd4;
  assign cand.br  = PC_D + 32'd4 + br_off;
  assign cand.jmp = {PC_D[31:28], index26_D, 2'b00};
  assign cand.jr  = jr_target_D;

  always_comb begin
    npc = cand.seq;
    unique case (npc_sel_e'(npc_sel))
      NPC_SEQ: npc = cand.seq;
      NPC_BR:  npc = br_taken ? cand.br : cand.seq;
      NPC_J:   npc = cand.jmp;
      NPC_JR:  npc = cand.jr;
      default: npc = cand.seq;
    endcase
  end

  // A stalled D re-presents its redirect, so redirects are simply dropped while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= PC_RESET;
      cnt_q <= '0;
    end else if (enable_F) begin
      pc_q  <= npc;
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_fault = (pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | ({1'b0, pc_q} >= IM_END);
  assign im_addr     = IM_AW'((pc_q - IM_BASE) >> 2);
  assign Instr_F     = fetch_fault ? 32'h0 : im_rdata;
  assign PC_F        = pc_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed vector table, async-reset sequences and a
// randomized run against an arithmetic reference model.
module tb_f_fetch_unit;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 0;
  logic        reset;
  logic        enable_F;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] PC_D;
  logic [15:0] imm16_D;
  logic [25:0] index26_D;
  logic [31:0] jr_target_D;
  logic [11:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] PC_F;
  logic [31:0] Instr_F;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  assign im_rdata = mem_word(im_addr);

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .enable_F(enable_F), .npc_sel(npc_sel),
    .br_taken(br_taken), .PC_D(PC_D), .imm16_D(imm16_D), .index26_D(index26_D),
    .jr_target_D(jr_target_D), .im_addr(im_addr), .im_rdata(im_rdata),
    .PC_F(PC_F), .Instr_F(Instr_F), .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state and rules, expressed as plain arithmetic.
  logic [31:0] m_pc, m_cnt;

  function automatic logic m_fault(input logic [31:0] pc);
    longint p = longint'(pc);
    return (p % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * 4096);
  endfunction

  function automatic logic [11:0] m_ia(input logic [31:0] pc);
    logic [31:0] off = pc - BASE;
    return 12'(off / 4);
  endfunction

  function automatic logic [31:0] m_npc(input logic [31:0] pc, input logic [1:0] sel,
                                        input logic tk, input logic [31:0] pcd,
                                        input logic [15:0] imm, input logic [25:0] idx,
                                        input logic [31:0] jrt);
    int soff = int'($signed(imm)) * 4;
    case (sel)
      2'd1:    return tk ? pcd + 32'd4 + 32'(soff) : pc + 32'd4;
      2'd2:    return (pcd & 32'hF000_0000) | (32'(idx) * 4);
      2'd3:    return jrt;
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic f = m_fault(m_pc);
    check({tag, ".pc"},    PC_F, m_pc);
    check({tag, ".cnt"},   fetch_cnt, m_cnt);
    check({tag, ".fault"}, 32'(fetch_fault), 32'(f));
    check({tag, ".ia"},    32'(im_addr), 32'(m_ia(m_pc)));
    check({tag, ".instr"}, Instr_F, f ? 32'h0 : mem_word(m_ia(m_pc)));
  endtask

  typedef struct {
    logic        en;
    logic [1:0]  sel;
    logic        tk;
    logic [31:0] pcd;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_flt;
    logic [11:0] e_ia;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic en, input logic [1:0] sel, input logic tk,
                       input logic [31:0] pcd, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jrt);
    enable_F = en; npc_sel = sel; br_taken = tk; PC_D = pcd;
    imm16_D = imm; index26_D = idx; jr_target_D = jrt;
  endtask

  initial begin
    tbl[0]  = '{1, 2'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,    32'h3004, 1,  0, 12'h001};
    tbl[1]  = '{1, 2'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,    32'h3008, 2,  0, 12'h002};
    tbl[2]  = '{1, 2'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,    32'h300C, 3,  0, 12'h003};
    tbl[3]  = '{1, 2'd1, 1, 32'h3004, 16'hFFFE, 26'h0,     32'h0,    32'h3000, 4,  0, 12'h000};
    tbl[4]  = '{1, 2'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,    32'h3004, 5,  0, 12'h001};
    tbl[5]  = '{1, 2'd0, 0, 32'h0,    16'h0,    26'h0,     32'h0,    32'h3008, 6,  0, 12'h002};
    tbl[6]  = '{1, 2'd1, 0, 32'h3004, 16'hFFFE, 26'h0,     32'h0,    32'h300C, 7,  0, 12'h003};
    tbl[7]  = '{1, 2'd2, 0, 32'h3010, 16'h0,    26'h0C10,  32'h0,    32'h3040, 8,  0, 12'h010};
    tbl[8]  = '{0, 2'd2, 0, 32'h3010, 16'h0,    26'h0C20,  32'h0,    32'h3040, 8,  0, 12'h010};
    tbl[9]  = '{0, 2'd2, 0, 32'h3010, 16'h0,    26'h0C20,  32'h0,    32'h3040, 8,  0, 12'h010};
    tbl[10] = '{1, 2'd2, 0, 32'h3010, 16'h0,    26'h0C20,  32'h0,    32'h3080, 9,  0, 12'h020};
    tbl[11] = '{1, 2'd3, 0, 32'h0,    16'h0,    26'h0,     32'h3100, 32'h3100, 10, 0, 12'h040};
    tbl[12] = '{1, 2'd3, 0, 32'h0,    16'h0,    26'h0,     32'h3102, 32'h3102, 11, 1, 12'h040};
    tbl[13] = '{1, 2'd3, 0, 32'h0,    16'h0,    26'h0,     32'h2FFC, 32'h2FFC, 12, 1, 12'hFFF};
    tbl[14] = '{1, 2'd3, 0, 32'h0,    16'h0,    26'h0,     32'h7000, 32'h7000, 13, 1, 12'h000};

    reset = 0;
    drive(0, 2'd0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #12;
    check("rst.pc", PC_F, 32'h3000);
    check("rst.cnt", fetch_cnt, 32'h0);
    check("rst.ia", 32'(im_addr), 32'h0);
    check("rst.instr", Instr_F, mem_word(12'h000));
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].sel, tbl[i].tk, tbl[i].pcd, tbl[i].imm, tbl[i].idx, tbl[i].jrt);
      @(posedge clk); #1;
      check($sformatf("vec%0d.pc", i), PC_F, tbl[i].e_pc);
      check($sformatf("vec%0d.cnt", i), fetch_cnt, tbl[i].e_cnt);
      check($sformatf("vec%0d.fault", i), 32'(fetch_fault), 32'(tbl[i].e_flt));
      check($sformatf("vec%0d.ia", i), 32'(im_addr), 32'(tbl[i].e_ia));
      check($sformatf("vec%0d.instr", i), Instr_F, tbl[i].e_flt ? 32'h0 : mem_word(tbl[i].e_ia));
    end

    // Upper window edge just inside.
    drive(1, 2'd3, 0, 32'h0, 16'h0, 26'h0, 32'h6FFC);
    @(posedge clk); #1;
    check("edge6ffc.fault", 32'(fetch_fault), 32'h0);
    check("edge6ffc.instr", Instr_F, mem_word(12'hFFF));

    // Mid-cycle async reset while stalled at 3040 with a jump pending.
    drive(1, 2'd2, 0, 32'h3010, 16'h0, 26'h0C10, 32'h0);
    @(posedge clk); #1;
    check("pre.pc", PC_F, 32'h3040);
    drive(0, 2'd2, 0, 32'h3010, 16'h0, 26'h0C20, 32'h0);
    @(posedge clk); #2;
    reset = 0;
    #1;
    check("async.pc", PC_F, 32'h3000);
    check("async.cnt", fetch_cnt, 32'h0);
    enable_F = 1;
    @(posedge clk); #1;
    check("held.pc", PC_F, 32'h3000);
    check("held.cnt", fetch_cnt, 32'h0);
    @(negedge clk);
    reset = 1;

    // Randomized run against the reference model.
    m_pc = 32'h3000; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        en  = ($urandom_range(0, 3) != 0);
      logic [1:0]  sel = 2'($urandom_range(0, 3));
      logic        tk  = 1'($urandom);
      logic [31:0] pcd = BASE + 32'($urandom_range(0, 4095)) * 4;
      logic [15:0] imm = 16'($urandom);
      logic [25:0] idx = 26'(BASE / 4) + 26'($urandom_range(0, 4200));
      logic [31:0] jrt = ($urandom_range(0, 7) == 0) ? $urandom
                                                     : BASE + 32'($urandom_range(0, 16400));
      drive(en, sel, tk, pcd, imm, idx, jrt);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 0;
        #1;
        m_pc = 32'h3000; m_cnt = 0;
        check_all("rnd.rst");
        #1 reset = 1;
      end
      @(posedge clk); #1;
      if (en) begin
        m_pc  = m_npc(m_pc, sel, tk, pcd, imm, idx, jrt);
        m_cnt = m_cnt + 1;
      end
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
